// File: rtl/ad5781_spi_responder.sv
// AD5781 serial-interface responder: decodes 24-bit SPI frames into the DAC register map.
// Define AD5781_READBACK_EN to build the miso readback path; otherwise miso is tied low.
module ad5781_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [19:0] DAC_RESET   = 20'h00000,
  parameter logic [19:0] CTRL_RESET  = 20'h0000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic        ldac_n,
  input  logic        clr_n,
  output logic [19:0] dac_out,
  output logic [19:0] ctrl_out,
  output logic        update,
  output logic        frame_err
);

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned NPINS      = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  // pin order: {clr_n, ldac_n, mosi, cs_n, sclk}
  localparam logic [NPINS-1:0] PIN_IDLE = 5'b11011;

  typedef enum logic [1:0] {ST_SKIP, ST_IDLE, ST_FRAME} state_t;

  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
  logic [NPINS-1:0] pins_s;
  logic [3:0]       edge_d;
  logic [SYNC_STAGES:0] arm_q;
  logic armed;

  logic sclk_fall, cs_fall, cs_rise, ldac_fall, clr_fall;
  logic mosi_s, ldac_s;

  state_t           state;
  logic [23:0]      rx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [19:0]      dac_reg;
  logic [19:0]      clear_code;
  logic             commit;
  logic             wr;
  logic [2:0]       fr_addr;
  logic [19:0]      fr_data;

  // Synchronizers; edges are qualified only once the chain holds real pin samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{PIN_IDLE}};
      edge_d <= 4'b1111;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {clr_n, ldac_n, mosi, cs_n, sclk}};
      edge_d <= {pins_s[4], pins_s[3], pins_s[1], pins_s[0]};
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign pins_s    = sync_q[SYNC_STAGES-1];
  assign armed     = arm_q[SYNC_STAGES];
  assign mosi_s    = pins_s[2];
  assign ldac_s    = pins_s[3];
  assign sclk_fall = armed &  edge_d[0] & ~pins_s[0];
  assign cs_fall   = armed &  edge_d[1] & ~pins_s[1];
  assign cs_rise   = armed & ~edge_d[1] &  pins_s[1];
  assign ldac_fall = armed &  edge_d[2] & ~pins_s[3];
  assign clr_fall  = armed &  edge_d[3] & ~pins_s[4];

  assign fr_addr = rx_sr[22:20];
  assign fr_data = rx_sr[19:0];
  assign commit  = (state == ST_FRAME) && cs_rise && (bit_cnt == CNT_FULL);
  assign wr      = commit && !rx_sr[23];

  // Frame tracking and register map; a clear is applied last so it overrides writes and LDAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SKIP;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      dac_reg    <= DAC_RESET;
      dac_out    <= DAC_RESET;
      ctrl_out   <= CTRL_RESET;
      clear_code <= '0;
      update     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        ST_SKIP: begin
          if (armed && pins_s[1]) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_FRAME;
            rx_sr   <= '0;
            bit_cnt <= '0;
          end
        end
        ST_FRAME: begin
          if (cs_rise) begin
            state     <= ST_IDLE;
            frame_err <= (bit_cnt != CNT_FULL);
          end else if (sclk_fall) begin
            rx_sr <= {rx_sr[22:0], mosi_s};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_SKIP;
      endcase

      if (ldac_fall) begin
        dac_out <= dac_reg;
        update  <= 1'b1;
      end

      if (wr) begin
        case (fr_addr)
          3'd1: begin
            dac_reg <= fr_data;
            if (!ldac_s) begin
              dac_out <= fr_data;
              update  <= 1'b1;
            end
          end
          3'd2: ctrl_out   <= fr_data;
          3'd3: clear_code <= fr_data;
          3'd4: begin
            if (fr_data[2]) begin
              dac_reg    <= DAC_RESET;
              dac_out    <= DAC_RESET;
              ctrl_out   <= CTRL_RESET;
              clear_code <= '0;
              update     <= 1'b1;
            end else if (fr_data[1]) begin
              dac_reg <= clear_code;
              dac_out <= clear_code;
              update  <= 1'b1;
            end else if (fr_data[0]) begin
              dac_out <= dac_reg;
              update  <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (clr_fall) begin
        dac_reg <= clear_code;
        dac_out <= clear_code;
        update  <= 1'b1;
      end
    end
  end

`ifdef AD5781_READBACK_EN
  logic        sclk_rise;
  logic        rb_pend;
  logic [2:0]  rb_addr;
  logic [19:0] rb_data;
  logic [23:0] tx_load;
  logic [23:0] tx_sr;
  logic        sdo_dis;

  assign sclk_rise = armed & ~edge_d[0] & pins_s[0];
  assign sdo_dis   = ctrl_out[5];
  assign tx_load   = rb_pend ? {1'b1, rb_addr, rb_data} : 24'h000000;

  always_comb begin
    rb_data = '0;
    case (rb_addr)
      3'd1:    rb_data = dac_reg;
      3'd2:    rb_data = ctrl_out;
      3'd3:    rb_data = clear_code;
      default: rb_data = '0;
    endcase
  end

  // Readback shifter: loaded at frame start, advanced on sclk rise after the first falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_pend <= 1'b0;
      rb_addr <= '0;
      tx_sr   <= '0;
      miso    <= 1'b0;
    end else begin
      if (commit && rx_sr[23]) begin
        rb_pend <= 1'b1;
        rb_addr <= fr_addr;
      end
      if (state == ST_IDLE && cs_fall) begin
        rb_pend <= 1'b0;
        tx_sr   <= {tx_load[22:0], 1'b0};
        miso    <= tx_load[23] & ~sdo_dis;
      end else if (state != ST_FRAME || cs_rise) begin
        miso <= 1'b0;
      end else if (sclk_rise && bit_cnt != '0) begin
        tx_sr <= {tx_sr[22:0], 1'b0};
        miso  <= tx_sr[23] & ~sdo_dis;
      end else if (sdo_dis) begin
        miso <= 1'b0;
      end
    end
  end
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_ad5781_spi_responder.sv
// Self-checking bench for ad5781_spi_responder: scoreboard of expected dac_out values at each update pulse.
`timescale 1ns/1ps
module tb_ad5781_spi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, cs_n, mosi, ldac_n, clr_n;
  logic        miso;
  logic [19:0] dac_out, ctrl_out;
  logic        update, frame_err;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  logic [23:0] cap_r;

  always #5 clk = ~clk;

  ad5781_spi_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .ldac_n(ldac_n), .clr_n(clr_n), .dac_out(dac_out), .ctrl_out(ctrl_out),
    .update(update), .frame_err(frame_err)
  );

  // Observer: every update-high cycle records dac_out, every frame_err-high cycle counts.
  always @(negedge clk) begin
    if (!reset) begin
      if (update) obs_q.push_back(dac_out);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [23:0] d, input int first, input int last);
    logic [23:0] t;
    for (int i = first; i <= last; i++) begin
      t = d << i;
      mosi = t[23];
      wait_clk(4);
      cap_r = {cap_r[22:0], miso};
      sclk = 1'b0;
      wait_clk(4);
      sclk = 1'b1;
    end
  endtask

  task automatic spi_send(input logic [23:0] d, input int nbits, input logic clr_at_close);
    cap_r = '0;
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(d, 0, nbits - 1);
    wait_clk(4);
    mosi = 1'b0;
    cs_n = 1'b1;
    if (clr_at_close) clr_n = 1'b0;
    wait_clk(12);
  endtask

  task automatic test_reset;
    reset = 1'b1; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0; ldac_n = 1'b1; clr_n = 1'b1;
    wait_clk(3);
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL rst_dac got %h want %h", dac_out, 20'h00000); end
    total++; if (ctrl_out !== 20'h0000C) begin bad++; $display("FAIL rst_ctrl got %h want %h", ctrl_out, 20'h0000C); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso got %b want 0", miso); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL rst_update got %b want 0", update); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    reset = 1'b0;
    wait_clk(10);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_no_update got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_write_ldac_low;
    logic [19:0] e, o;
    ldac_n = 1'b0;
    exp_q.push_back(20'h00000);
    wait_clk(8);
    exp_q.push_back(20'hABCDE);
    spi_send(24'h1ABCDE, 24, 1'b0);
    total++; if (dac_out !== 20'hABCDE) begin bad++; $display("FAIL wr_dac got %h want %h", dac_out, 20'hABCDE); end
    total++; if (ferr_cnt != 0) begin bad++; $display("FAIL wr_ferr got %0d want 0", ferr_cnt); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL wr_upd_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wr_upd_val got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ldac_edge;
    logic [19:0] e, o;
    ldac_n = 1'b1;
    wait_clk(8);
    spi_send(24'h112345, 24, 1'b0);
    total++; if (dac_out !== 20'hABCDE) begin bad++; $display("FAIL ldac_hold got %h want %h", dac_out, 20'hABCDE); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ldac_no_upd got %0d want 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back(20'h12345);
    ldac_n = 1'b0;
    wait_clk(8);
    total++; if (dac_out !== 20'h12345) begin bad++; $display("FAIL ldac_load got %h want %h", dac_out, 20'h12345); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ldac_upd_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL ldac_upd_val got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear;
    logic [19:0] e, o;
    spi_send(24'h380000, 24, 1'b0);
    exp_q.push_back(20'h80000);
    spi_send(24'h111111, 24, 1'b1);
    total++; if (dac_out !== 20'h80000) begin bad++; $display("FAIL clr_dac got %h want %h", dac_out, 20'h80000); end
    clr_n = 1'b1;
    ldac_n = 1'b1;
    wait_clk(8);
    exp_q.push_back(20'h80000);
    ldac_n = 1'b0;
    wait_clk(8);
    total++; if (dac_out !== 20'h80000) begin bad++; $display("FAIL clr_dacreg got %h want %h", dac_out, 20'h80000); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL clr_upd_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL clr_upd_val got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = ferr_cnt;
    spi_send(24'h1FFFFF, 23, 1'b0);
    total++; if (ferr_cnt != f0 + 1) begin bad++; $display("FAIL ferr_short got %0d want %0d", ferr_cnt, f0 + 1); end
    spi_send(24'h2FFFFF, 25, 1'b0);
    total++; if (ferr_cnt != f0 + 2) begin bad++; $display("FAIL ferr_long got %0d want %0d", ferr_cnt, f0 + 2); end
    total++; if (dac_out !== 20'h80000) begin bad++; $display("FAIL ferr_dac got %h want %h", dac_out, 20'h80000); end
    total++; if (ctrl_out !== 20'h0000C) begin bad++; $display("FAIL ferr_ctrl got %h want %h", ctrl_out, 20'h0000C); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ferr_no_upd got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_swctrl;
    logic [19:0] e, o;
    ldac_n = 1'b1;
    wait_clk(8);
    spi_send(24'h155555, 24, 1'b0);
    total++; if (dac_out !== 20'h80000) begin bad++; $display("FAIL sw_hold got %h want %h", dac_out, 20'h80000); end
    exp_q.push_back(20'h55555);
    spi_send(24'h400001, 24, 1'b0);
    total++; if (dac_out !== 20'h55555) begin bad++; $display("FAIL sw_load got %h want %h", dac_out, 20'h55555); end
    spi_send(24'h200012, 24, 1'b0);
    total++; if (ctrl_out !== 20'h00012) begin bad++; $display("FAIL sw_ctrl got %h want %h", ctrl_out, 20'h00012); end
    exp_q.push_back(20'h00000);
    spi_send(24'h400006, 24, 1'b0);
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL sw_rst_dac got %h want %h", dac_out, 20'h00000); end
    total++; if (ctrl_out !== 20'h0000C) begin bad++; $display("FAIL sw_rst_ctrl got %h want %h", ctrl_out, 20'h0000C); end
    spi_send(24'h122222, 24, 1'b0);
    exp_q.push_back(20'h00000);
    spi_send(24'h400003, 24, 1'b0);
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL sw_clr_prio got %h want %h", dac_out, 20'h00000); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sw_upd_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL sw_upd_val got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_readback;
    logic [23:0] want;
`ifdef AD5781_READBACK_EN
    want = 24'hA00012;
`else
    want = 24'h000000;
`endif
    spi_send(24'h200012, 24, 1'b0);
    spi_send(24'hA00000, 24, 1'b0);
    spi_send(24'h000000, 24, 1'b0);
    total++; if (cap_r !== want) begin bad++; $display("FAIL rb_data got %h want %h", cap_r, want); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rb_idle got %b want 0", miso); end
    spi_send(24'h200032, 24, 1'b0);
    total++; if (ctrl_out !== 20'h00032) begin bad++; $display("FAIL rb_ctrl got %h want %h", ctrl_out, 20'h00032); end
    spi_send(24'hA00000, 24, 1'b0);
    spi_send(24'h000000, 24, 1'b0);
    total++; if (cap_r !== 24'h000000) begin bad++; $display("FAIL rb_sdodis got %h want %h", cap_r, 24'h000000); end
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL rb_dac got %h want %h", dac_out, 20'h00000); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rb_no_upd got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_midframe;
    logic [19:0] e, o;
    int f0;
    exp_q.push_back(20'h00000);
    ldac_n = 1'b0;
    wait_clk(8);
    exp_q.push_back(20'h13579);
    spi_send(24'h113579, 24, 1'b0);
    total++; if (dac_out !== 20'h13579) begin bad++; $display("FAIL mid_pre got %h want %h", dac_out, 20'h13579); end
    f0 = ferr_cnt;
    cs_n = 1'b0;
    wait_clk(4);
    shift_bits(24'h1ABCDE, 0, 11);
    reset = 1'b1;
    #1;
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL mid_rst_dac got %h want %h", dac_out, 20'h00000); end
    total++; if (ctrl_out !== 20'h0000C) begin bad++; $display("FAIL mid_rst_ctrl got %h want %h", ctrl_out, 20'h0000C); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL mid_rst_miso got %b want 0", miso); end
    wait_clk(3);
    reset = 1'b0;
    shift_bits(24'h1ABCDE, 12, 23);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(12);
    total++; if (dac_out !== 20'h00000) begin bad++; $display("FAIL mid_no_commit got %h want %h", dac_out, 20'h00000); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL mid_no_ferr got %0d want %0d", ferr_cnt, f0); end
    exp_q.push_back(20'h2468A);
    spi_send(24'h12468A, 24, 1'b0);
    total++; if (dac_out !== 20'h2468A) begin bad++; $display("FAIL mid_recover got %h want %h", dac_out, 20'h2468A); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_upd_cnt got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mid_upd_val got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_ldac_low();
    test_ldac_edge();
    test_clear();
    test_frame_err();
    test_swctrl();
    test_readback();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
